// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the debug memory scanner: bus word, scanner states
// and the word-alignment helper applied to every issued address.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        CAPTURE,
        DWELL
    } scan_state_t;

    localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic word_t word_align(input word_t a);
        return a & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero, and the
// count never wraps below zero.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !done) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/dbg_mem_scanner.sv
// Debug memory port sequencer: while the CPU is halted, reads one word (manual)
// or walks an address window (auto) and holds the capture for the display.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | port released; cursor tracks the manual/start address
//   ISSUE   | tb_addr presents the cursor, settle timer loaded
//   SETTLE  | waiting SETTLE cycles for tb_load to become valid
//   CAPTURE | latch tb_load into the display registers
//   DWELL   | auto mode: hold the capture DWELL unpaused cycles, then advance
module dbg_mem_scanner
    import cpu_types_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int DWELL  = 50000000,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              mode,
    input  logic              pause,
    input  logic [ADDR_W-1:0] manual_addr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              tb_ctrl,
    output logic              tb_ren,
    output word_t             tb_addr,
    input  word_t             tb_load,
    output word_t             disp_word,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic              busy
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [DW-1:0] DWELL_LOAD  = DW'(DWELL - 1);

    scan_state_t       state, state_next;
    logic [ADDR_W-1:0] cursor, cursor_next;
    logic [ADDR_W-1:0] manual_al, start_al, end_al, advance_addr;
    logic [ADDR_W:0]   cursor_inc;
    logic              settle_load, settle_en, settle_done;
    logic              dwell_load, dwell_en, dwell_done;
    logic              capture;

    assign manual_al = ADDR_W'(word_align(word_t'(manual_addr)));
    assign start_al  = ADDR_W'(word_align(word_t'(start_addr)));
    assign end_al    = ADDR_W'(word_align(word_t'(end_addr)));

    // Wrapping when the cursor is already at/after the end also makes an
    // inverted window collapse to the single start word.
    assign cursor_inc   = {1'b0, cursor} + (ADDR_W + 1)'(4);
    assign advance_addr = (cursor >= end_al || cursor_inc[ADDR_W]) ? start_al
                                                                   : cursor_inc[ADDR_W-1:0];

    scan_timer #(.W(SW)) u_settle_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (settle_load),
        .en       (settle_en),
        .load_val (SETTLE_LOAD),
        .done     (settle_done)
    );

    scan_timer #(.W(DW)) u_dwell_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (dwell_load),
        .en       (dwell_en),
        .load_val (DWELL_LOAD),
        .done     (dwell_done)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= cpu_types_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cursor_next = cursor;
        settle_load = 1'b0;
        settle_en   = 1'b0;
        dwell_load  = 1'b0;
        dwell_en    = 1'b0;
        capture     = 1'b0;
        case (state)
            cpu_types_pkg::IDLE: begin
                cursor_next = mode ? start_al : manual_al;
                state_next  = cpu_types_pkg::ISSUE;
            end
            cpu_types_pkg::ISSUE: begin
                settle_load = 1'b1;
                state_next  = cpu_types_pkg::SETTLE;
            end
            cpu_types_pkg::SETTLE: begin
                settle_en = 1'b1;
                if (settle_done) begin
                    state_next = cpu_types_pkg::CAPTURE;
                end
            end
            cpu_types_pkg::CAPTURE: begin
                capture = 1'b1;
                if (!mode) begin
                    cursor_next = manual_al;
                    state_next  = cpu_types_pkg::ISSUE;
                end else begin
                    dwell_load = 1'b1;
                    state_next = cpu_types_pkg::DWELL;
                end
            end
            cpu_types_pkg::DWELL: begin
                if (!mode) begin
                    cursor_next = manual_al;
                    state_next  = cpu_types_pkg::ISSUE;
                end else if (!pause) begin
                    dwell_en = 1'b1;
                    if (dwell_done) begin
                        cursor_next = advance_addr;
                        state_next  = cpu_types_pkg::ISSUE;
                    end
                end
            end
            default: state_next = cpu_types_pkg::IDLE;
        endcase
        // Losing halt releases the port from any state and discards a pending capture.
        if (!halt) begin
            state_next  = cpu_types_pkg::IDLE;
            settle_load = 1'b0;
            settle_en   = 1'b0;
            dwell_load  = 1'b0;
            dwell_en    = 1'b0;
            capture     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cursor     <= '0;
            tb_addr    <= '0;
            disp_word  <= '0;
            disp_addr  <= '0;
            disp_valid <= 1'b0;
        end else begin
            cursor  <= cursor_next;
            tb_addr <= (state_next == cpu_types_pkg::IDLE) ? '0 : word_t'(cursor_next);
            if (capture) begin
                disp_word <= tb_load;
                disp_addr <= cursor;
            end
            if (!halt) begin
                disp_valid <= 1'b0;
            end else if (capture) begin
                disp_valid <= 1'b1;
            end
        end
    end

    assign busy    = (state != cpu_types_pkg::IDLE);
    assign tb_ctrl = busy;
    assign tb_ren  = busy;

endmodule

// File: tb/tb_dbg_mem_scanner.sv
// Directed-plus-random bench for dbg_mem_scanner with a behavioural memory and
// an address-sequence model derived from the window/dwell rules.
module tb_dbg_mem_scanner;

    localparam int S      = 2;
    localparam int D      = 4;
    localparam int AW     = 16;
    localparam int PERIOD = D + S + 2;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          halt;
    logic          mode;
    logic          pause;
    logic [AW-1:0] manual_addr;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          tb_ctrl;
    logic          tb_ren;
    logic [31:0]   tb_addr;
    logic [31:0]   tb_load;
    logic [31:0]   disp_word;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   salt;
    logic [AW-1:0] last_addr;
    logic [31:0]   last_word;

    dbg_mem_scanner #(.SETTLE(S), .DWELL(D), .ADDR_W(AW)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .halt        (halt),
        .mode        (mode),
        .pause       (pause),
        .manual_addr (manual_addr),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .tb_ctrl     (tb_ctrl),
        .tb_ren      (tb_ren),
        .tb_addr     (tb_addr),
        .tb_load     (tb_load),
        .disp_word   (disp_word),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // Memory: one marker word at 0x40, otherwise address + 0x100 + salt.
    assign tb_load = (tb_addr == 32'h40) ? 32'hDEADBEEF : tb_addr + 32'h100 + salt;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {16'h0, a};
        return (w == 32'h40) ? 32'hDEADBEEF : w + 32'h100 + salt;
    endfunction

    function automatic logic [AW-1:0] al(input logic [AW-1:0] a);
        return a & 16'hFFFC;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] cur,
                                                input logic [AW-1:0] s,
                                                input logic [AW-1:0] e);
        int c;
        c = int'(cur);
        if (c >= int'(al(e)) || c + 4 > 65535) return al(s);
        return AW'(c + 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic released(input string tag);
        chk({tag, "_busy"}, {tb_ctrl, tb_ren, busy}, 32'h0);
        chk({tag, "_tb_addr"}, tb_addr, 32'h0);
        chk({tag, "_valid"}, disp_valid, 32'h0);
        chk({tag, "_keep_addr"}, disp_addr, last_addr);
        chk({tag, "_keep_word"}, disp_word, last_word);
    endtask

    task automatic auto_scan(input logic [AW-1:0] s, input logic [AW-1:0] e, input int n,
                             input int pause_k, input int pause_len);
        logic [AW-1:0] cur, nxt;
        start_addr = s;
        end_addr   = e;
        mode       = 1'b1;
        pause      = 1'b0;
        halt       = 1'b1;
        cur        = al(s);
        step(1);
        chk("auto_issue_addr", tb_addr, {16'h0, cur});
        chk("auto_issue_busy", {tb_ctrl, tb_ren, busy}, 32'h7);
        step(S + 1);
        chk("auto_first_early", disp_valid, 32'h0);
        step(1);
        chk("auto_first_addr", disp_addr, cur);
        chk("auto_first_word", disp_word, mem_word(cur));
        chk("auto_first_valid", disp_valid, 32'h1);
        for (int k = 1; k < n; k++) begin
            nxt = next_addr(cur, s, e);
            if (k == pause_k) begin
                pause = 1'b1;
                for (int p = 0; p < pause_len; p++) begin
                    step(1);
                    chk("pause_tb_addr", tb_addr, {16'h0, cur});
                end
                pause = 1'b0;
            end
            step(PERIOD - 1);
            chk("dwell_hold_addr", disp_addr, cur);
            step(1);
            chk("scan_addr", disp_addr, nxt);
            chk("scan_word", disp_word, mem_word(nxt));
            chk("scan_tb_addr", tb_addr, {16'h0, nxt});
            cur = nxt;
        end
        last_addr = cur;
        last_word = mem_word(cur);
        halt = 1'b0;
        step(1);
        released("auto_halt_drop");
    endtask

    initial begin
        logic [AW-1:0] ma;
        logic [AW-1:0] rs;

        nRST        = 1'b0;
        halt        = 1'b0;
        mode        = 1'b0;
        pause       = 1'b0;
        manual_addr = '0;
        start_addr  = '0;
        end_addr    = '0;
        salt        = '0;
        last_addr   = '0;
        last_word   = '0;
        step(3);
        nRST = 1'b1;
        released("reset");

        for (int i = 0; i < 100; i++) begin
            mode        = 1'($urandom_range(0, 1));
            manual_addr = AW'($urandom_range(0, 16'hFFFF));
            step(1);
            chk("no_halt_idle", {tb_ctrl, tb_ren, busy, disp_valid}, 32'h0);
        end

        mode        = 1'b0;
        manual_addr = 16'h0043;
        halt        = 1'b1;
        step(1);
        chk("man_issue_addr", tb_addr, 32'h40);
        chk("man_issue_busy", {tb_ctrl, tb_ren, busy}, 32'h7);
        step(S + 1);
        chk("man_early_valid", disp_valid, 32'h0);
        step(1);
        chk("man_word", disp_word, 32'hDEADBEEF);
        chk("man_addr", disp_addr, 32'h40);
        chk("man_valid", disp_valid, 32'h1);

        salt = $urandom;
        for (int i = 0; i < 6; i++) begin
            ma          = AW'($urandom_range(0, 16'hFFFF));
            manual_addr = ma;
            step(S + 2);
            chk("man_refresh_tb_addr", tb_addr, {16'h0, al(ma)});
            step(S + 2);
            chk("man_refresh_addr", disp_addr, al(ma));
            chk("man_refresh_word", disp_word, mem_word(al(ma)));
        end
        last_addr = al(ma);
        last_word = mem_word(al(ma));
        halt = 1'b0;
        step(1);
        released("man_halt_drop");

        salt = '0;
        auto_scan(16'h0010, 16'h0018, 5, 0, 0);
        salt = $urandom;
        auto_scan(16'h0010, 16'h0018, 4, 2, 20);

        // Auto to manual while dwelling: leaves DWELL on the next edge.
        start_addr = 16'h0010;
        end_addr   = 16'h0018;
        mode       = 1'b1;
        halt       = 1'b1;
        step(S + 3);
        chk("sw_auto_addr", disp_addr, 32'h10);
        ma          = AW'($urandom_range(16'h0100, 16'hFFFF));
        mode        = 1'b0;
        manual_addr = ma;
        step(1);
        chk("sw_tb_addr", tb_addr, {16'h0, al(ma)});
        step(S + 1);
        chk("sw_hold_addr", disp_addr, 32'h10);
        step(1);
        chk("sw_man_addr", disp_addr, al(ma));
        chk("sw_man_word", disp_word, mem_word(al(ma)));
        last_addr = al(ma);
        last_word = mem_word(al(ma));
        halt = 1'b0;
        step(1);
        released("sw_halt_drop");

        // halt drops while settling, then the scan restarts at start_addr.
        start_addr = 16'h0030;
        end_addr   = 16'h0038;
        mode       = 1'b1;
        halt       = 1'b1;
        step(2);
        chk("settle_busy", busy, 32'h1);
        halt = 1'b0;
        step(1);
        released("settle_halt_drop");
        auto_scan(16'h0030, 16'h0038, 3, 0, 0);

        auto_scan(16'hFFF8, 16'hFFFC, 4, 0, 0);
        auto_scan(16'h0020, 16'h0010, 3, 0, 0);

        for (int i = 0; i < 3; i++) begin
            salt = $urandom;
            rs   = AW'($urandom_range(0, 16'hFFFF));
            auto_scan(rs, AW'(rs + AW'($urandom_range(0, 20))), 5,
                      $urandom_range(0, 4), $urandom_range(1, 10));
        end

        // Asynchronous reset in the middle of a scan.
        salt       = '0;
        start_addr = 16'h0010;
        end_addr   = 16'h0018;
        mode       = 1'b1;
        halt       = 1'b1;
        step(S + 3);
        chk("pre_reset_word", disp_word, 32'h110);
        #2 nRST = 1'b0;
        #1;
        last_addr = '0;
        last_word = '0;
        released("async_reset");
        halt = 1'b0;
        step(1);
        nRST = 1'b1;
        step(2);
        chk("post_reset_idle", {tb_ctrl, tb_ren, busy, disp_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
